// File: rtl/centroid_crosshair.sv
`default_nettype none
// ============================================================================
// Module : centroid_crosshair
// Mask centroid per frame (saturating accumulators + two serial dividers)
// and a registered crosshair select for the video mux.
// Rev    : 1.0
// ============================================================================
module centroid_crosshair #(
    parameter int H_BITS = 11,
    parameter int V_BITS = 10
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [H_BITS-1:0] hcount_in,
    input  logic [V_BITS-1:0] vcount_in,
    input  logic              data_valid_in,
    input  logic              thresholded_pixel_in,
    input  logic              new_frame_in,
    output logic [H_BITS-1:0] x_out,
    output logic [V_BITS-1:0] y_out,
    output logic              valid_out,
    output logic              busy_out,
    output logic              crosshair_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_sum_x;
    logic [31:0] r_sum_y;
    logic [20:0] r_count;
    logic [20:0] r_div;
    logic [20:0] r_rem_x;
    logic [20:0] r_rem_y;
    logic [31:0] r_quo_x;
    logic [31:0] r_quo_y;
    logic [4:0]  r_step;

    logic        w_pix;
    logic [32:0] w_sx_add;
    logic [32:0] w_sy_add;
    logic [31:0] w_sx_next;
    logic [31:0] w_sy_next;
    logic [20:0] w_cnt_next;
    logic [52:0] w_step_x;
    logic [52:0] w_step_y;

    // One restoring step: returns {remainder, quotient shifted left with new bit}.
    // The quotient register starts out holding the dividend and drains MSB-first.
    function automatic logic [52:0] div_step(input logic [20:0] rem,
                                             input logic [31:0] quo,
                                             input logic [20:0] div);
        logic [21:0] trial;
        logic [21:0] diff;
        trial = {rem, quo[31]};
        diff  = trial - {1'b0, div};
        if (diff[21])
            return {trial[20:0], quo[30:0], 1'b0};
        else
            return {diff[20:0], quo[30:0], 1'b1};
    endfunction

    assign w_pix      = data_valid_in & thresholded_pixel_in;
    assign w_sx_add   = {1'b0, r_sum_x} + 33'(hcount_in);
    assign w_sy_add   = {1'b0, r_sum_y} + 33'(vcount_in);
    assign w_sx_next  = w_sx_add[32] ? '1 : w_sx_add[31:0];
    assign w_sy_next  = w_sy_add[32] ? '1 : w_sy_add[31:0];
    assign w_cnt_next = (r_count == '1) ? r_count : r_count + 21'd1;
    assign w_step_x   = div_step(r_rem_x, r_quo_x, r_div);
    assign w_step_y   = div_step(r_rem_y, r_quo_y, r_div);
    assign busy_out   = (r_state == DIVIDE);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state       <= IDLE;
            r_sum_x       <= '0;
            r_sum_y       <= '0;
            r_count       <= '0;
            r_div         <= '0;
            r_rem_x       <= '0;
            r_rem_y       <= '0;
            r_quo_x       <= '0;
            r_quo_y       <= '0;
            r_step        <= '0;
            x_out         <= '0;
            y_out         <= '0;
            valid_out     <= 1'b0;
            crosshair_out <= 1'b0;
        end else begin
            valid_out     <= 1'b0;
            crosshair_out <= data_valid_in & ((hcount_in == x_out) | (vcount_in == y_out));

            // A pixel arriving with the frame pulse belongs to the next frame.
            if (new_frame_in) begin
                r_sum_x <= w_pix ? 32'(hcount_in) : '0;
                r_sum_y <= w_pix ? 32'(vcount_in) : '0;
                r_count <= w_pix ? 21'd1 : '0;
            end else if (w_pix) begin
                r_sum_x <= w_sx_next;
                r_sum_y <= w_sy_next;
                r_count <= w_cnt_next;
            end

            case (r_state)
                IDLE: begin
                    if (new_frame_in) begin
                        r_div   <= r_count;
                        r_quo_x <= r_sum_x;
                        r_quo_y <= r_sum_y;
                        r_rem_x <= '0;
                        r_rem_y <= '0;
                        r_step  <= '0;
                        r_state <= (r_count == '0) ? IDLE : DIVIDE;
                    end
                end
                DIVIDE: begin
                    {r_rem_x, r_quo_x} <= w_step_x;
                    {r_rem_y, r_quo_y} <= w_step_y;
                    r_step             <= r_step + 5'd1;
                    if (r_step == 5'd31)
                        r_state <= DONE;
                end
                DONE: begin
                    x_out     <= r_quo_x[H_BITS-1:0];
                    y_out     <= r_quo_y[V_BITS-1:0];
                    valid_out <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_centroid_crosshair.sv
`default_nettype none
// Bench for centroid_crosshair: scoreboard of expected centroids and
// crosshair bits, checked against DUT outputs as they appear.
module tb_centroid_crosshair;

    localparam int H_BITS = 11;
    localparam int V_BITS = 10;

    logic              clk_in = 1'b0;
    logic              rst_n_in;
    logic [H_BITS-1:0] hcount_in;
    logic [V_BITS-1:0] vcount_in;
    logic              data_valid_in;
    logic              thresholded_pixel_in;
    logic              new_frame_in;
    logic [H_BITS-1:0] x_out;
    logic [V_BITS-1:0] y_out;
    logic              valid_out;
    logic              busy_out;
    logic              crosshair_out;

    int n_checks = 0;
    int n_pass   = 0;

    logic [H_BITS-1:0] exp_x_q[$];
    logic [V_BITS-1:0] exp_y_q[$];
    logic              exp_ch_q[$];

    centroid_crosshair #(.H_BITS(H_BITS), .V_BITS(V_BITS)) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .hcount_in           (hcount_in),
        .vcount_in           (vcount_in),
        .data_valid_in       (data_valid_in),
        .thresholded_pixel_in(thresholded_pixel_in),
        .new_frame_in        (new_frame_in),
        .x_out               (x_out),
        .y_out               (y_out),
        .valid_out           (valid_out),
        .busy_out            (busy_out),
        .crosshair_out       (crosshair_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive_pixel(input int h, input int v);
        hcount_in            = H_BITS'(h);
        vcount_in            = V_BITS'(v);
        data_valid_in        = 1'b1;
        thresholded_pixel_in = 1'b1;
        tick();
        data_valid_in        = 1'b0;
        thresholded_pixel_in = 1'b0;
    endtask

    // Pulses new_frame_in and watches the outputs; second_at>0 injects a
    // masked pixel and then another frame pulse while the divider runs.
    task automatic end_frame(input int second_at, input int watch,
                             output int first_valid, output int n_valid,
                             output logic [H_BITS-1:0] got_x,
                             output logic [V_BITS-1:0] got_y,
                             output bit saw_busy);
        first_valid  = 0;
        n_valid      = 0;
        got_x        = '0;
        got_y        = '0;
        saw_busy     = 1'b0;
        new_frame_in = 1'b1;
        for (int n = 1; n <= watch; n++) begin
            tick();
            new_frame_in         = 1'b0;
            data_valid_in        = 1'b0;
            thresholded_pixel_in = 1'b0;
            if (busy_out === 1'b1) saw_busy = 1'b1;
            if (valid_out === 1'b1) begin
                n_valid++;
                if (first_valid == 0) begin
                    first_valid = n;
                    got_x       = x_out;
                    got_y       = y_out;
                end
            end
            if (second_at != 0 && n == second_at - 2) begin
                hcount_in            = 11'd500;
                vcount_in            = 10'd300;
                data_valid_in        = 1'b1;
                thresholded_pixel_in = 1'b1;
            end
            if (second_at != 0 && n == second_at) new_frame_in = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n_in             = 1'b0;
        hcount_in            = '0;
        vcount_in            = '0;
        data_valid_in        = 1'b0;
        thresholded_pixel_in = 1'b0;
        new_frame_in         = 1'b0;
        #2;
        n_checks++;
        if ({x_out, y_out, valid_out, busy_out, crosshair_out} !== '0)
            $display("FAIL reset_outputs: got x=%0d y=%0d v=%b b=%b c=%b, need all 0",
                     x_out, y_out, valid_out, busy_out, crosshair_out);
        else n_pass++;
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        n_checks++;
        if ({valid_out, busy_out} !== 2'b00)
            $display("FAIL reset_release: got valid=%b busy=%b, need 0 0", valid_out, busy_out);
        else n_pass++;
    endtask

    task automatic check_result(input string name, input int first_valid, input int n_valid,
                                input logic [H_BITS-1:0] got_x, input logic [V_BITS-1:0] got_y,
                                input bit saw_busy);
        logic [H_BITS-1:0] ex;
        logic [V_BITS-1:0] ey;
        n_checks++;
        if (first_valid != 34) $display("FAIL %s_latency: got %0d, need 34", name, first_valid);
        else n_pass++;
        n_checks++;
        if (n_valid != 1) $display("FAIL %s_pulses: got %0d, need 1", name, n_valid);
        else n_pass++;
        n_checks++;
        if (!saw_busy) $display("FAIL %s_busy: got 0, need 1 during divide", name);
        else n_pass++;
        n_checks++;
        if (exp_x_q.size() == 0) begin
            $display("FAIL %s_scoreboard: got result with empty queue, need an entry", name);
        end else begin
            ex = exp_x_q.pop_front();
            ey = exp_y_q.pop_front();
            if (got_x !== ex || got_y !== ey)
                $display("FAIL %s_xy: got (%0d,%0d), need (%0d,%0d)", name, got_x, got_y, ex, ey);
            else n_pass++;
        end
    endtask

    task automatic test_single_pixel();
        int fv, nv;
        logic [H_BITS-1:0] gx;
        logic [V_BITS-1:0] gy;
        bit sb;
        drive_pixel(100, 50);
        exp_x_q.push_back(11'd100);
        exp_y_q.push_back(10'd50);
        end_frame(0, 40, fv, nv, gx, gy, sb);
        check_result("single", fv, nv, gx, gy, sb);
    endtask

    task automatic test_crosshair();
        logic exp_c;
        for (int v = 45; v < 55; v++) begin
            for (int h = 0; h < 128; h++) begin
                hcount_in     = H_BITS'(h);
                vcount_in     = V_BITS'(v);
                data_valid_in = (h < 120);
                exp_ch_q.push_back((h < 120) && (h == 100 || v == 50));
                tick();
                exp_c = exp_ch_q.pop_front();
                n_checks++;
                if (crosshair_out !== exp_c)
                    $display("FAIL crosshair h=%0d v=%0d: got %b, need %b", h, v, crosshair_out, exp_c);
                else n_pass++;
            end
        end
        data_valid_in = 1'b0;
        tick();
    endtask

    task automatic test_truncation();
        int fv, nv;
        logic [H_BITS-1:0] gx;
        logic [V_BITS-1:0] gy;
        bit sb;
        drive_pixel(10, 20);
        drive_pixel(11, 20);
        drive_pixel(13, 21);
        exp_x_q.push_back(11'd11);
        exp_y_q.push_back(10'd20);
        end_frame(0, 40, fv, nv, gx, gy, sb);
        check_result("trunc", fv, nv, gx, gy, sb);
    endtask

    task automatic test_empty_frame();
        int fv, nv;
        logic [H_BITS-1:0] gx;
        logic [V_BITS-1:0] gy;
        bit sb;
        end_frame(0, 40, fv, nv, gx, gy, sb);
        n_checks++;
        if (nv != 0) $display("FAIL empty_valid: got %0d pulses, need 0", nv);
        else n_pass++;
        n_checks++;
        if (sb) $display("FAIL empty_busy: got busy=1, need 0");
        else n_pass++;
        n_checks++;
        if (x_out !== 11'd11 || y_out !== 10'd20)
            $display("FAIL empty_hold: got (%0d,%0d), need (11,20)", x_out, y_out);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int fv, nv;
        logic [H_BITS-1:0] gx;
        logic [V_BITS-1:0] gy;
        bit sb;
        drive_pixel(200, 30);
        drive_pixel(202, 31);
        exp_x_q.push_back(11'd201);
        exp_y_q.push_back(10'd30);
        end_frame(11, 40, fv, nv, gx, gy, sb);
        check_result("b2b", fv, nv, gx, gy, sb);
        // Follow-up frame with no pixels: a cleared count means no division.
        end_frame(0, 40, fv, nv, gx, gy, sb);
        n_checks++;
        if (nv != 0 || sb) $display("FAIL b2b_zero_count: got %0d pulses busy=%b, need 0 0", nv, sb);
        else n_pass++;
        n_checks++;
        if (x_out !== 11'd201 || y_out !== 10'd30)
            $display("FAIL b2b_hold: got (%0d,%0d), need (201,30)", x_out, y_out);
        else n_pass++;
    endtask

    task automatic test_reset_mid_divide();
        int fv, nv;
        logic [H_BITS-1:0] gx;
        logic [V_BITS-1:0] gy;
        bit sb;
        drive_pixel(300, 400);
        new_frame_in  = 1'b1;
        tick();
        new_frame_in  = 1'b0;
        hcount_in     = 11'd201;
        vcount_in     = 10'd0;
        data_valid_in = 1'b1;
        repeat (5) tick();
        n_checks++;
        if (busy_out !== 1'b1 || crosshair_out !== 1'b1)
            $display("FAIL rst_pre: got busy=%b cross=%b, need 1 1", busy_out, crosshair_out);
        else n_pass++;
        #2;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if ({x_out, y_out, valid_out, busy_out, crosshair_out} !== '0)
            $display("FAIL rst_async: got x=%0d y=%0d v=%b b=%b c=%b, need all 0",
                     x_out, y_out, valid_out, busy_out, crosshair_out);
        else n_pass++;
        data_valid_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        nv = 0;
        sb = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (valid_out === 1'b1) nv++;
            if (busy_out === 1'b1) sb = 1'b1;
        end
        n_checks++;
        if (nv != 0 || sb) $display("FAIL rst_abort: got %0d pulses busy=%b, need 0 0", nv, sb);
        else n_pass++;
        drive_pixel(7, 9);
        exp_x_q.push_back(11'd7);
        exp_y_q.push_back(10'd9);
        end_frame(0, 40, fv, nv, gx, gy, sb);
        check_result("rst_next", fv, nv, gx, gy, sb);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_crosshair();
        test_truncation();
        test_empty_frame();
        test_back_to_back();
        test_reset_mid_divide();
        n_checks++;
        if (exp_x_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left, need 0", exp_x_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/centroid_crosshair.md
CENTROID_CROSSHAIR -- requirements
Module: centroid_crosshair

Interface
REQ-001 The module SHALL have parameter H_BITS, default 11, giving the width of the horizontal pixel coordinate.
REQ-002 The module SHALL have parameter V_BITS, default 10, giving the width of the vertical pixel coordinate.
REQ-003 The module SHALL have port clk_in  input  1  as its single clock; all logic is on the rising edge.
REQ-004 The module SHALL have port rst_n_in  input  1  as its reset, asynchronous and active-low.
REQ-005 The module SHALL have port hcount_in  input  H_BITS  giving the current pixel column.
REQ-006 The module SHALL have port vcount_in  input  V_BITS  giving the current pixel row.
REQ-007 The module SHALL have port data_valid_in  input  1  marking the pixel as in the active area.
REQ-008 The module SHALL have port thresholded_pixel_in  input  1  carrying the mask bit from the color threshold stage.
REQ-009 The module SHALL have port new_frame_in  input  1  as a one-cycle end-of-frame pulse.
REQ-010 The module SHALL have port x_out  output  H_BITS  giving the latest centroid column.
REQ-011 The module SHALL have port y_out  output  V_BITS  giving the latest centroid row.
REQ-012 The module SHALL have port valid_out  output  1  as a one-cycle pulse when x_out/y_out update.
REQ-013 The module SHALL have port busy_out  output  1  that is high while the divider runs.
REQ-014 The module SHALL have port crosshair_out  output  1  feeding the video mux crosshair select.

Function
REQ-015 Accumulation: on each cycle with data_valid_in=1 and thresholded_pixel_in=1, the module SHALL add hcount_in to sum_x (32b), vcount_in to sum_y (32b) and 1 to count (21b).
REQ-016 Frame end: on new_frame_in=1 in IDLE, the module SHALL latch sum_x, sum_y and count into divider operands, clear the accumulators, and enter DIVIDE.
REQ-017 A qualifying pixel coincident with new_frame_in SHALL count toward the next frame: the accumulators load that pixel's values instead of zero.
REQ-018 The state machine SHALL have three states: IDLE, DIVIDE and DONE; busy_out=1 exactly in DIVIDE.
REQ-019 DIVIDE SHALL run two restoring dividers in parallel (sum_x/count, sum_y/count), one quotient bit per cycle, for 32 cycles, then go to DONE.
REQ-020 In DONE (one cycle), x_out and y_out SHALL take the low H_BITS and V_BITS of the quotients (truncating division), valid_out SHALL pulse for that cycle, and the state SHALL return to IDLE.
REQ-021 Latency from the new_frame_in cycle to valid_out SHALL be exactly 34 cycles.
REQ-022 If the latched count=0, the module SHALL skip DIVIDE and return to IDLE next cycle, with x_out/y_out held and no valid_out pulse.
REQ-023 If new_frame_in arrives in DIVIDE or DONE, the module SHALL clear the accumulators (per REQ-017) and discard that frame's result; the running division SHALL be unaffected.
REQ-024 Accumulators SHALL saturate, not wrap: count at 2^21-1, sums at 2^32-1.
REQ-025 crosshair_out SHALL be registered (one-cycle latency) and equal to data_valid_in AND (hcount_in==x_out OR vcount_in==y_out), using x_out/y_out as they were in the cycle of the inputs.
REQ-026 x_out and y_out SHALL change only in DONE.

Reset
REQ-027 While rst_n_in=0, the module SHALL set state=IDLE, all accumulators and divider registers to 0, x_out=0, y_out=0, valid_out=0, busy_out=0 and crosshair_out=0, immediately and without a clock.
REQ-028 Reset asserted mid-DIVIDE SHALL abort the division; after release, no valid_out SHALL occur until a new frame completes.

Verification
REQ-029 The bench SHALL check: single mask pixel at (100,50), then new_frame_in -> valid_out at +34 cycles, x_out=100, y_out=50.
REQ-030 The bench SHALL check: mask pixels at (10,20), (11,20), (13,21), then new_frame_in -> x_out=11, y_out=20 (truncation).
REQ-031 The bench SHALL check: frame with zero mask pixels -> no valid_out, x_out/y_out retain prior values, busy_out never asserts.
REQ-032 The bench SHALL check: second new_frame_in 10 cycles into DIVIDE -> first result still delivered at +34; the second frame produces no valid_out; an accumulator count of 0 follows.
REQ-033 The bench SHALL check: with x_out=100, y_out=50, scanning a full frame -> crosshair_out=1 one cycle after every pixel with hcount_in=100 or vcount_in=50, and 0 elsewhere and outside data_valid_in.
REQ-034 The bench SHALL check: rst_n_in low for 3 cycles mid-DIVIDE -> all outputs 0 asynchronously, no valid_out after release until the next frame completes.
